mac_seq_ctrl: RTL and testbench

//  Sequencer for one registered-operand MAC slice (operands latched on acc_en; result = held acc + product).

---
 rtl/mac_seq_pkg.sv | 29 ++
 rtl/mac_seq_ctrl_if.sv | 38 +++
 rtl/mac_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer: default widths, FSM state
// encodings and the result saturation limits.
package mac_seq_pkg;

  localparam int OWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 27;
  localparam int RWIDTH_DEF = 16;
  localparam int CWIDTH_DEF = 10;

  // Sequencer states: plain 3-bit constants so the encoding stays visible
  // in waveforms and legacy netlists.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CLEAR   = 3'd1;
  localparam state_t ST_ACCUM   = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_OUT     = 3'd4;

  // Largest signed value representable in rw bits.
  function automatic longint sat_hi(input int rw);
    return (64'sd1 <<< (rw - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in rw bits.
  function automatic longint sat_lo(input int rw);
    return -(64'sd1 <<< (rw - 1));
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle between the MAC sequencer and its surroundings: command
// channel, operand stream, MAC control/result and the result channel.
// slave  = sequencer view, master = environment view (command source,
// operand fetch, the MAC itself and the result sink).
interface mac_seq_ctrl_if #(
  parameter int OWIDTH = 8,
  parameter int AWIDTH = 27,
  parameter int RWIDTH = 16,
  parameter int CWIDTH = 10
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CWIDTH-1:0]        cmd_len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OWIDTH-1:0] in_a;
  logic signed [OWIDTH-1:0] in_b;
  logic signed [OWIDTH-1:0] mac_a;
  logic signed [OWIDTH-1:0] mac_b;
  logic                     mac_acc_en;
  logic                     mac_clr;
  logic signed [AWIDTH-1:0] mac_result;
  logic                     res_valid;
  logic                     res_ready;
  logic [RWIDTH-1:0]        res_data;

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_a, in_b, mac_result, res_ready,
    output cmd_ready, in_ready, mac_a, mac_b, mac_acc_en, mac_clr,
           res_valid, res_data
  );

  modport master (
    output cmd_valid, cmd_len, in_valid, in_a, in_b, mac_result, res_ready,
    input  cmd_ready, in_ready, mac_a, mac_b, mac_acc_en, mac_clr,
           res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one registered-operand MAC slice.
// Accepts a length-N command, clears the MAC, streams N operand pairs into
// it, captures the sum and presents it on a valid/ready result port.
// Optional feature: define MACSEQ_SAT_EN to saturate the captured sum to
// the result width instead of truncating it.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int RWIDTH = RWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [RWIDTH-1:0] res_data_q, res_data_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              in_ready_q, in_ready_d;
  logic              mac_clr_q, mac_clr_d;
  logic [RWIDTH-1:0] res_capt_s;

`ifdef MACSEQ_SAT_EN
  longint res_ext_s;
  longint res_lim_s;

  // Clamp the MAC sum into the signed result range before capture.
  always_comb begin
    res_ext_s = longint'($signed(bus.mac_result));
    if (res_ext_s > sat_hi(RWIDTH)) begin
      res_lim_s = sat_hi(RWIDTH);
    end else if (res_ext_s < sat_lo(RWIDTH)) begin
      res_lim_s = sat_lo(RWIDTH);
    end else begin
      res_lim_s = res_ext_s;
    end
    res_capt_s = RWIDTH'(res_lim_s);
  end
`else
  // Keep only the low result bits; overflow wraps.
  assign res_capt_s = RWIDTH'(bus.mac_result);
`endif

  // Sequencer next state, remaining-pair count and result register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cnt_d   = bus.cmd_len;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q != {CWIDTH{1'b0}}) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q - {{(CWIDTH-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CWIDTH-1){1'b0}}, 1'b1}) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_CAPTURE: begin
        res_data_d  = res_capt_s;
        res_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_OUT;
        end
      end
      default: begin
        cnt_d       = {CWIDTH{1'b0}};
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Handshake/control outputs decoded from the upcoming state so they leave
  // the block straight from flops.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    in_ready_d  = (state_d == ST_ACCUM);
    mac_clr_d   = (state_d == ST_CLEAR);
  end

  // State and output registers; reset drops any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CWIDTH{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {RWIDTH{1'b0}};
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      mac_clr_q   <= mac_clr_d;
    end
  end

  // Operands go straight to the MAC; it only latches them on acc_en, which
  // must track the live in_valid to let the producer stall.
  assign bus.mac_a      = bus.in_a;
  assign bus.mac_b      = bus.in_b;
  assign bus.mac_acc_en = bus.in_valid & in_ready_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural MAC slice.
// Honours MACSEQ_SAT_EN the same way the design does.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if bus ();

  mac_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural registered-operand MAC: operands latched on acc_en, the
  // accumulator absorbs the previously latched product.
  logic signed [7:0]  ma_q, mb_q;
  logic signed [26:0] macc_q;
  always_ff @(posedge clk) begin
    if (bus.mac_clr) begin
      ma_q <= 8'sd0; mb_q <= 8'sd0; macc_q <= 27'sd0;
    end else if (bus.mac_acc_en) begin
      ma_q <= bus.mac_a; mb_q <= bus.mac_b;
      macc_q <= macc_q + 27'(ma_q) * 27'(mb_q);
    end
  end
  assign bus.mac_result = macc_q + 27'(ma_q) * 27'(mb_q);

  int n_checks = 0;
  int n_fail   = 0;
  int va [16];
  int vb [16];

  // Expected result: exact dot product, then fitted to 16 bits.
  function automatic int ref_res(input int len);
    int s; int t;
    s = 0;
    for (int i = 0; i < len; i++) s += va[i] * vb[i];
`ifdef MACSEQ_SAT_EN
    if (s > 32767) t = 32767;
    else if (s < -32768) t = -32768;
    else t = s;
`else
    t = s & 32'h0000FFFF;
    if (t >= 32768) t = t - 65536;
`endif
    return t;
  endfunction

  // Drive one command with 'stall' idle cycles before every pair but the
  // first; return latency (cycles after accept to first res_valid) and
  // counts of acc_en / mac_clr cycles. Leaves the bench in the first OUT cycle.
  task automatic do_cmd(input int len, input int stall, output int lat,
                        output int accs, output int clrs, output bit tmo);
    int cyc; int idx; int st;
    tmo = 1'b0; lat = 0; accs = 0; clrs = 0;
    bus.cmd_valid = 1'b1; bus.cmd_len = 10'(len);
    cyc = 0;
    while (!bus.cmd_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (!bus.cmd_ready) begin
      tmo = 1'b1; bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1; idx = 0; st = 0;
    while (!bus.res_valid && lat < 5000) begin
      if (idx < len && st == 0) begin
        bus.in_valid = 1'b1; bus.in_a = 8'(va[idx]); bus.in_b = 8'(vb[idx]);
      end else begin
        bus.in_valid = 1'b0; bus.in_a = 8'(32'($urandom)); bus.in_b = 8'(32'($urandom));
      end
      #1;
      if (bus.mac_clr) clrs++;
      if (bus.mac_acc_en) begin
        accs++; idx++; st = stall;
      end else if (bus.in_ready && st > 0) begin
        st--;
      end
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    if (!bus.res_valid) tmo = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.mac_clr !== 1'b0 ||
        bus.mac_acc_en !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: cmd_ready=%b in_ready=%b clr=%b acc_en=%b res_valid=%b res_data=%0d, want 1 0 0 0 0 0",
               bus.cmd_ready, bus.in_ready, bus.mac_clr, bus.mac_acc_en, bus.res_valid, bus.res_data);
    end
  endtask

  // Run a command with res_ready high and check result, latency, enables.
  task automatic run_and_check(input string nm, input int len, input int stall);
    int lat; int accs; int clrs; bit tmo; int exp_lat;
    bus.res_ready = 1'b1;
    do_cmd(len, stall, lat, accs, clrs, tmo);
    exp_lat = len + 3 + ((len > 0) ? stall * (len - 1) : 0);
    n_checks++;
    if (tmo) begin
      n_fail++; $display("FAIL %s_timeout: no result within bound", nm);
      return;
    end
    n_checks++;
    if (bus.res_data !== 16'(ref_res(len))) begin
      n_fail++; $display("FAIL %s_data: got %0d want %0d", nm, $signed(bus.res_data), ref_res(len));
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat);
    end
    n_checks++;
    if (accs !== len || clrs !== 1) begin
      n_fail++; $display("FAIL %s_enables: acc_en %0d clr %0d want %0d 1", nm, accs, clrs, len);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_release: res_valid=%b cmd_ready=%b want 0 1", nm, bus.res_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin va[i] = i + 1; vb[i] = i + 5; end
    run_and_check("basic70", 4, 0);
  endtask

  task automatic test_stall();
    va[0] = -3; va[1] = 2; va[2] = -1;
    vb[0] = 4;  vb[1] = 5; vb[2] = -6;
    run_and_check("stall4", 3, 2);
  endtask

  task automatic test_zero_len();
    run_and_check("len0", 0, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin va[i] = -128; vb[i] = -128; end
    run_and_check("ovf", 8, 0);
  endtask

  task automatic test_backpressure();
    int lat; int accs; int clrs; bit tmo; logic [15:0] d0;
    for (int i = 0; i < 3; i++) begin
      va[i] = int'($urandom_range(255)) - 128; vb[i] = int'($urandom_range(255)) - 128;
    end
    bus.res_ready = 1'b0;
    do_cmd(3, 0, lat, accs, clrs, tmo);
    n_checks++;
    if (tmo || bus.res_data !== 16'(ref_res(3))) begin
      n_fail++; $display("FAIL bp_data: tmo=%b got %0d want %0d", tmo, $signed(bus.res_data), ref_res(3));
    end
    d0 = 16'(ref_res(3));
    bus.cmd_valid = 1'b1; bus.cmd_len = 10'd2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d res_valid=%b data=%0d cmd_ready=%b want 1 %0d 0",
                 c, bus.res_valid, $signed(bus.res_data), bus.cmd_ready, $signed(d0));
      end
    end
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.mac_clr !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: res_valid=%b cmd_ready=%b clr=%b want 0 1 0",
                         bus.res_valid, bus.cmd_ready, bus.mac_clr);
    end
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_len = 10'd5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = 8'sd7; bus.in_b = 8'sd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.mac_acc_en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: res_valid=%b cmd_ready=%b in_ready=%b acc_en=%b want 0 1 0 0",
                         bus.res_valid, bus.cmd_ready, bus.in_ready, bus.mac_acc_en);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    va[0] = 1; va[1] = 1; vb[0] = 1; vb[1] = 1;
    run_and_check("after_reset", 2, 0);
  endtask

  task automatic test_random();
    int len; int stall;
    for (int it = 0; it < 20; it++) begin
      len = int'($urandom_range(12));
      stall = int'($urandom_range(2));
      for (int i = 0; i < len; i++) begin
        va[i] = int'($urandom_range(255)) - 128;
        vb[i] = int'($urandom_range(255)) - 128;
      end
      run_and_check("rand", len, stall);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_len = 10'd0; bus.in_valid = 1'b0;
    bus.in_a = 8'sd0; bus.in_b = 8'sd0; bus.res_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_zero_len();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
